spi_slave_rx: RTL and testbench
===============================

# spi_slave_rx

Serial-to-parallel receiver that sits directly downstream of the SPI master transmitter. It recovers DATA_WIDTH-bit words from the SCK/MOSI pair, MSB first, sampling MOSI on SCK rising edges after synchronising both lines into the local clock domain. Each completed word is presented on a one-entry valid/ready output register. The block flags overruns, and discards stalled partial frames after a timeout.

## Interface
- DATA_WIDTH, 8, bits per word; must be ≥ 2.
- TIMEOUT_CYCLES, 64, number of clk_i cycles without an SCK rising edge after which a partial frame is discarded; must be ≥ 4.

- clk_i  input  1  system clock.
- reset_n_i  input  1  reset; asynchronous, active-low.
- SCK_i  input  1  serial clock from the master; asynchronous to clk_i.
- MOSI_i  input  1  serial data from the master; asynchronous to clk_i.
- data_o  output  DATA_WIDTH  received word; valid while valid_o=1.
- valid_o  output  1  output word available.
- ready_i  input  1  consumer accepts data_o when valid_o && ready_i at a rising clk_i edge.
- overrun_o  output  1  sticky flag; a completed word was dropped because the output register was full.
- clear_overrun_i  input  1  single-cycle pulse that clears overrun_o.
- frame_err_o  output  1  one-cycle pulse; a partial frame was discarded on timeout.

## Operation
- Synchroniser: SCK_i and MOSI_i each pass through two flops (sync1→sync2). A third flop, sck_d, holds the previous sync2 value of SCK.
- A rising edge is detected when sck_sync2=1 and sck_d=0. The sampled bit is mosi_sync2 in that same cycle.
- FSM states:
  - IDLE: bit counter = 0, timeout counter held at 0. On a rising edge: shift in the bit, set the counter to 1, go to SHIFT.
  - SHIFT: on each rising edge, shift in the bit (shift_reg <= {shift_reg[DATA_WIDTH-2:0], bit}) and increment the counter. When the edge carries bit number DATA_WIDTH (counter == DATA_WIDTH-1 before the edge), hand the complete word to the output stage, clear the counter and return to IDLE.
  - SHIFT timeout: the timeout counter increments on every cycle without a rising edge and clears on every rising edge. On reaching TIMEOUT_CYCLES: clear the shift register and bit counter, pulse frame_err_o for one cycle, and return to IDLE.
- Output stage hand-off, when a word completes:
  - If valid_o=0, or valid_o && ready_i in the same cycle: load data_o and set valid_o=1.
  - Otherwise: drop the new word, keep data_o unchanged, and set overrun_o=1.
- Acceptance: valid_o && ready_i with no new word clears valid_o. data_o holds its last value.
- overrun_o clearing: clear_overrun_i clears overrun_o. If an overrun occurs in the same cycle as clear_overrun_i, overrun_o stays 1.
- Counter widths:
  - Bit counter: $clog2(DATA_WIDTH+1) bits.
  - Timeout counter: $clog2(TIMEOUT_CYCLES+1) bits; it saturates and never wraps.

## Timing
- Reset values: data_o=0, valid_o=0, overrun_o=0, frame_err_o=0. The shift register, counters and all sync flops are 0 and the FSM is in IDLE. Reset mid-frame discards the partial word with no frame_err_o pulse.
- Latency: if clk_i edge k is the first to sample the final SCK_i high, then valid_o and data_o are updated after edge k+2.
- MOSI_i must be stable from 2 cycles before until 1 cycle after the SCK_i rising sample.
- Maximum SCK rate: SCK_i high and low phases must each last ≥ 1 clk_i cycle. An SCK that toggles every clk_i cycle is supported.
- Back-to-back words: a new frame's first edge may occur in the same cycle as the previous word's hand-off.
- frame_err_o pulses exactly TIMEOUT_CYCLES cycles after the last detected edge of a partial frame. There is no timeout in IDLE.

## Test plan
- Single word: send 0xA5 with SCK toggling every cycle, ready_i=1 → valid_o high for 1 cycle, data_o=0xA5, overrun_o=0.
- Back-pressure/overrun: ready_i=0, send 0x3C then 0xC3 → data_o stays 0x3C, overrun_o=1. Raise ready_i → 0x3C accepted, valid_o=0. Pulse clear_overrun_i → overrun_o=0.
- Simultaneous accept and arrival: hold 0x11 valid, assert ready_i in the completion cycle of 0x22 → data_o=0x22, valid_o stays 1, no overrun.
- Timeout: send 5 bits, then stop SCK for 64 cycles → frame_err_o pulses once. A following full word 0x0F is received exactly.
- Reset mid-frame: deassert reset_n_i after 3 bits → all outputs 0 immediately. After release, word 0xFF is received correctly.
- Slow SCK: SCK high 7 cycles, low 9 cycles (period 16), DATA_WIDTH=16, word 0xBEEF → data_o=0xBEEF, frame_err_o never asserts.

Source files
------------

// File: rtl/spi_slave_rx.sv
// spi_slave_rx
//   Serial-to-parallel SPI receiver. SCK_i and MOSI_i are brought into the
//   clk_i domain through two-flop synchronisers. MOSI is sampled on each
//   detected SCK rising edge and shifted in MSB first. Each completed
//   DATA_WIDTH-bit word is offered on a one-entry valid/ready output register.
//   A partial frame that sees no SCK rising edge for TIMEOUT_CYCLES cycles is
//   discarded and reported with a one-cycle frame_err_o pulse.
//
// Ports
//   clk_i            system clock
//   reset_n_i        asynchronous active-low reset
//   SCK_i, MOSI_i    serial clock / data from the master (asynchronous)
//   data_o           received word, meaningful while valid_o = 1
//   valid_o          output word available
//   ready_i          consumer takes data_o when valid_o && ready_i
//   overrun_o        sticky: a completed word was dropped (output full)
//   clear_overrun_i  pulse that clears overrun_o
//   frame_err_o      one-cycle pulse: partial frame discarded on timeout
module spi_slave_rx #(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  SCK_i,
    input  logic                  MOSI_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  overrun_o,
    input  logic                  clear_overrun_i,
    output logic                  frame_err_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state;
    logic                    sck_sync1;
    logic                    sck_sync2;
    logic                    sck_d;
    logic                    mosi_sync1;
    logic                    mosi_sync2;
    // Only DATA_WIDTH-1 bits are kept: the final bit of a word goes straight
    // into the output register together with these, so a full-width shift
    // register would carry a bit that is never read.
    logic [DATA_WIDTH-2:0]   shift_reg;
    logic [CNT_W-1:0]        bit_cnt;
    logic [TMO_W-1:0]        tmo_cnt;

    logic                    rise;
    logic [DATA_WIDTH-1:0]   word_next;
    logic                    word_done;
    logic                    drop;

    // ---- synchronisers and edge history ----
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sck_sync1  <= 1'b0;
            sck_sync2  <= 1'b0;
            sck_d      <= 1'b0;
            mosi_sync1 <= 1'b0;
            mosi_sync2 <= 1'b0;
        end else begin
            sck_sync1  <= SCK_i;
            sck_sync2  <= sck_sync1;
            sck_d      <= sck_sync2;
            mosi_sync1 <= MOSI_i;
            mosi_sync2 <= mosi_sync1;
        end
    end

    assign rise      = sck_sync2 & ~sck_d;
    assign word_next = {shift_reg, mosi_sync2};
    // DATA_WIDTH >= 2, so the edge that leaves IDLE can never complete a word.
    assign word_done = rise && (state == SHIFT) && (bit_cnt == LAST_BIT);
    assign drop      = word_done && valid_o && !ready_i;

    // ---- frame FSM: shifting, bit count, timeout ----
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_cnt     <= '0;
            tmo_cnt     <= '0;
            frame_err_o <= 1'b0;
        end else begin
            frame_err_o <= 1'b0;
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    bit_cnt <= '0;
                    if (rise) begin
                        shift_reg <= word_next[DATA_WIDTH-2:0];
                        bit_cnt   <= CNT_W'(1);
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (rise) begin
                        shift_reg <= word_next[DATA_WIDTH-2:0];
                        tmo_cnt   <= '0;
                        if (word_done) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end else if (tmo_cnt >= TMO_LAST) begin
                        // TIMEOUT_CYCLES edgeless cycles reached this cycle.
                        shift_reg   <= '0;
                        bit_cnt     <= '0;
                        tmo_cnt     <= '0;
                        frame_err_o <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---- output register and overrun flag ----
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_o    <= '0;
            valid_o   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            if (word_done) begin
                // An accept in the same cycle frees the slot for the new word.
                if (!valid_o || ready_i) begin
                    data_o  <= word_next;
                    valid_o <= 1'b1;
                end
            end else if (valid_o && ready_i) begin
                valid_o <= 1'b0;
            end

            // A new overrun wins over a simultaneous clear.
            if (drop) begin
                overrun_o <= 1'b1;
            end else if (clear_overrun_i) begin
                overrun_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rx.sv
// tb_spi_slave_rx
//   Bench for spi_slave_rx. An 8-bit instance covers table-driven words,
//   back-pressure, simultaneous accept/arrival, timeout, mid-frame reset and
//   random traffic against a queue of sent words. A 16-bit instance covers a
//   slow SCK frame.
module tb_spi_slave_rx;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sck, mosi, ready, clr_ovr;
    logic [7:0]  data;
    logic        valid, ovr, ferr;
    logic        sck16, mosi16, ready16, clr_ovr16;
    logic [15:0] data16;
    logic        valid16, ovr16, ferr16;

    int total = 0;
    int bad   = 0;
    int ferr_cnt   = 0;
    int ferr16_cnt = 0;
    logic [7:0] rxq[$];
    logic [7:0] expq[$];

    typedef struct {
        logic [7:0] word;
        int         hi;
        int         lo;
        logic [7:0] exp_data;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    spi_slave_rx #(.DATA_WIDTH(8), .TIMEOUT_CYCLES(64)) dut (
        .clk_i(clk), .reset_n_i(reset_n), .SCK_i(sck), .MOSI_i(mosi),
        .data_o(data), .valid_o(valid), .ready_i(ready), .overrun_o(ovr),
        .clear_overrun_i(clr_ovr), .frame_err_o(ferr)
    );

    spi_slave_rx #(.DATA_WIDTH(16), .TIMEOUT_CYCLES(64)) dut16 (
        .clk_i(clk), .reset_n_i(reset_n), .SCK_i(sck16), .MOSI_i(mosi16),
        .data_o(data16), .valid_o(valid16), .ready_i(ready16), .overrun_o(ovr16),
        .clear_overrun_i(clr_ovr16), .frame_err_o(ferr16)
    );

    // Record every word actually taken by the consumer, and every error pulse.
    always @(negedge clk) begin
        if (valid && ready) rxq.push_back(data);
        if (ferr) ferr_cnt++;
        if (ferr16) ferr16_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic s, input logic m);
        if (sel) begin
            sck16 = s; mosi16 = m;
        end else begin
            sck = s; mosi = m;
        end
    endtask

    // Send val[nbits-1:0] MSB first; each bit is a low phase then a high
    // phase. Returns with SCK still high.
    task automatic send_bits(input logic [15:0] val, input int nbits,
                             input int hi, input int lo, input bit sel);
        for (int i = nbits - 1; i >= 0; i--) begin
            drive(sel, 1'b0, val[i]);
            repeat (lo) tick();
            drive(sel, 1'b1, val[i]);
            repeat (hi) tick();
        end
    endtask

    task automatic send_word(input logic [7:0] w, input int hi, input int lo);
        send_bits({8'h00, w}, 8, hi, lo, 1'b0);
        sck = 1'b0;
    endtask

    initial begin
        int n;
        int first;
        int pulses;
        int f0;
        logic [7:0] w;

        vecs[0] = '{8'hA5, 1, 1, 8'hA5};
        vecs[1] = '{8'h5A, 2, 1, 8'h5A};
        vecs[2] = '{8'h00, 1, 3, 8'h00};
        vecs[3] = '{8'hFF, 3, 2, 8'hFF};
        vecs[4] = '{8'h81, 1, 1, 8'h81};
        vecs[5] = '{8'h7E, 4, 4, 8'h7E};

        reset_n = 1'b0;
        sck = 0; mosi = 0; ready = 0; clr_ovr = 0;
        sck16 = 0; mosi16 = 0; ready16 = 0; clr_ovr16 = 0;
        repeat (3) tick();
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        chk("rst_ovr", 32'(ovr), 32'h0);
        chk("rst_ferr", 32'(ferr), 32'h0);
        reset_n = 1'b1;
        tick();

        // Table-driven single words with ready held high.
        ready = 1'b1;
        foreach (vecs[k]) begin
            rxq.delete();
            send_word(vecs[k].word, vecs[k].hi, vecs[k].lo);
            n = 0;
            while (rxq.size() == 0 && n < 12) begin
                tick();
                n++;
            end
            repeat (4) tick();
            chk($sformatf("vec%0d_count", k), 32'(rxq.size()), 32'd1);
            if (rxq.size() > 0) chk($sformatf("vec%0d_data", k), 32'(rxq[0]), 32'(vecs[k].exp_data));
            chk($sformatf("vec%0d_valid", k), 32'(valid), 32'h0);
            chk($sformatf("vec%0d_ovr", k), 32'(ovr), 32'h0);
        end

        // Back-pressure and overrun.
        ready = 1'b0;
        rxq.delete();
        send_word(8'h3C, 1, 1);
        repeat (4) tick();
        chk("bp_first_valid", 32'(valid), 32'h1);
        chk("bp_first_data", 32'(data), 32'h3C);
        chk("bp_first_ovr", 32'(ovr), 32'h0);
        send_word(8'hC3, 1, 1);
        repeat (4) tick();
        chk("bp_hold_data", 32'(data), 32'h3C);
        chk("bp_hold_valid", 32'(valid), 32'h1);
        chk("bp_ovr_set", 32'(ovr), 32'h1);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("bp_accept_valid", 32'(valid), 32'h0);
        chk("bp_accept_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("bp_accept_data", 32'(rxq[0]), 32'h3C);
        chk("bp_ovr_sticky", 32'(ovr), 32'h1);
        clr_ovr = 1'b1;
        tick();
        clr_ovr = 1'b0;
        chk("bp_ovr_clear", 32'(ovr), 32'h0);

        // Accept of 0x11 in the same cycle 0x22 completes.
        rxq.delete();
        send_word(8'h11, 1, 1);
        repeat (4) tick();
        chk("sim_first_data", 32'(data), 32'h11);
        send_bits(16'h0011, 7, 1, 1, 1'b0);
        sck = 1'b0; mosi = 1'b0;
        tick();
        sck = 1'b1;
        tick();
        sck = 1'b0;
        tick();
        ready = 1'b1;
        tick();
        ready = 1'b0;
        chk("sim_data", 32'(data), 32'h22);
        chk("sim_valid", 32'(valid), 32'h1);
        chk("sim_ovr", 32'(ovr), 32'h0);
        chk("sim_taken", 32'(rxq.size()), 32'd1);
        ready = 1'b1;
        tick();
        chk("sim_drain_valid", 32'(valid), 32'h0);

        // Timeout: five bits, then SCK stops.
        rxq.delete();
        f0 = ferr_cnt;
        send_bits(16'h000B, 4, 1, 1, 1'b0);
        sck = 1'b0; mosi = 1'b1;
        tick();
        sck = 1'b1;
        first = 0;
        pulses = 0;
        for (int c = 1; c <= 100; c++) begin
            tick();
            if (c == 1) sck = 1'b0;
            if (ferr) begin
                pulses++;
                if (first == 0) first = c;
            end
        end
        chk("tmo_pulses", 32'(pulses), 32'd1);
        chk("tmo_when", 32'(first), 32'd67);
        chk("tmo_no_word", 32'(rxq.size()), 32'd0);
        send_word(8'h0F, 1, 1);
        repeat (6) tick();
        chk("tmo_next_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("tmo_next_data", 32'(rxq[0]), 32'h0F);
        chk("tmo_ferr_total", 32'(ferr_cnt - f0), 32'd1);

        // Reset in the middle of a frame, with a word pending and overrun set.
        ready = 1'b0;
        send_word(8'h55, 1, 1);
        send_word(8'hAA, 1, 1);
        repeat (4) tick();
        chk("rstm_pre_valid", 32'(valid), 32'h1);
        chk("rstm_pre_ovr", 32'(ovr), 32'h1);
        f0 = ferr_cnt;
        send_bits(16'h0007, 3, 1, 1, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        chk("rstm_data", 32'(data), 32'h0);
        chk("rstm_valid", 32'(valid), 32'h0);
        chk("rstm_ovr", 32'(ovr), 32'h0);
        chk("rstm_ferr", 32'(ferr), 32'h0);
        sck = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        ready = 1'b1;
        rxq.delete();
        tick();
        send_word(8'hFF, 1, 1);
        repeat (100) tick();
        chk("rstm_next_count", 32'(rxq.size()), 32'd1);
        if (rxq.size() > 0) chk("rstm_next_data", 32'(rxq[0]), 32'hFF);
        chk("rstm_no_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Random words and phase lengths; the consumer is always ready, so
        // every sent word must come out in order.
        rxq.delete();
        expq.delete();
        f0 = ferr_cnt;
        for (int r = 0; r < 20; r++) begin
            w = 8'($urandom);
            expq.push_back(w);
            send_word(w, $urandom_range(1, 3), $urandom_range(1, 3));
        end
        repeat (8) tick();
        chk("rand_count", 32'(rxq.size()), 32'(expq.size()));
        for (int r = 0; r < expq.size() && r < rxq.size(); r++)
            chk($sformatf("rand_word%0d", r), 32'(rxq[r]), 32'(expq[r]));
        chk("rand_ovr", 32'(ovr), 32'h0);
        chk("rand_ferr", 32'(ferr_cnt - f0), 32'd0);

        // Slow SCK on the 16-bit instance.
        f0 = ferr16_cnt;
        send_bits(16'hBEEF, 16, 7, 9, 1'b1);
        sck16 = 1'b0;
        repeat (12) tick();
        chk("slow_valid", 32'(valid16), 32'h1);
        chk("slow_data", 32'(data16), 32'hBEEF);
        chk("slow_ovr", 32'(ovr16), 32'h0);
        chk("slow_ferr", 32'(ferr16_cnt - f0), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
